// File: rtl/pd1_pwr_ctrl_fsm.sv
// PD1 power-mode controller: RUN -> SLEEP -> RUN. It drives the target levels for the PD1 delay
// sequencer, then waits for the sequencer feedback before it advances to the next state.
`timescale 1ns/1ps

module pd1_pwr_ctrl_fsm #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TMR_W       = 16
) (
    input  logic       i_aon_clk,
    input  logic       i_soc_pwr_on_rst,
    input  logic       i_sleep_req,
    input  logic       i_wakeup_req,
    input  logic       i_pg_en,
    input  logic       i_hw_sleep_ack,
    input  logic       i_pwr_on_ack,
    input  logic       i_seq_clk_en,
    input  logic       i_seq_iso,
    input  logic       i_seq_rstn,
    input  logic       i_seq_pwr_on_req,
    output logic       o_sleep_req,
    output logic       o_clk_en,
    output logic       o_iso,
    output logic       o_ret,
    output logic       o_rstn,
    output logic       o_pwr_on_req_fsm,
    output logic       o_in_sleep,
    output logic       o_sleep_abort,
    output logic       o_ack_timeout,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SLP_REQ = 3'd1,
        ST_OFF_SEQ = 3'd2,
        ST_SLEEP   = 3'd3,
        ST_PWR_UP  = 3'd4,
        ST_ON_SEQ  = 3'd5
    } state_t;

    localparam logic [TMR_W-1:0] CNT_MAX = TMR_W'(ACK_TIMEOUT);

    state_t           state_q;
    state_t           state_d;
    logic             pg_q;
    logic             pg_d;
    logic [TMR_W-1:0] cnt_q;
    logic             cnt_max;

    logic sleep_req_d;
    logic clk_en_d;
    logic iso_d;
    logic ret_d;
    logic rstn_d;
    logic pwr_on_req_d;
    logic in_sleep_d;
    logic abort_d;
    logic timeout_d;

    assign cnt_max = (cnt_q == CNT_MAX);
    assign o_state = state_q;

    // The wait counter restarts on every state change and saturates instead of wrapping.
    always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
        if (i_soc_pwr_on_rst) begin
            state_q <= ST_RUN;
            pg_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pg_q    <= pg_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (((state_q == ST_SLP_REQ) || (state_q == ST_PWR_UP)) && !cnt_max) begin
                cnt_q <= cnt_q + TMR_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pg_d    = pg_q;
        case (state_q)
            ST_RUN: begin
                if (i_sleep_req && !i_wakeup_req) begin
                    state_d = ST_SLP_REQ;
                    pg_d    = i_pg_en;
                end
            end
            ST_SLP_REQ: begin
                if (i_wakeup_req || !i_sleep_req || cnt_max) begin
                    state_d = ST_RUN;
                end else if (i_hw_sleep_ack) begin
                    state_d = ST_OFF_SEQ;
                end
            end
            ST_OFF_SEQ: begin
                if (!i_seq_clk_en && !i_seq_rstn &&
                    (!pg_q || (!i_seq_pwr_on_req && !i_pwr_on_ack))) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (i_wakeup_req || !i_sleep_req) begin
                    state_d = ST_PWR_UP;
                end
            end
            ST_PWR_UP: begin
                if (i_pwr_on_ack) begin
                    state_d = ST_ON_SEQ;
                end
            end
            ST_ON_SEQ: begin
                if (i_seq_clk_en && !i_seq_iso && i_seq_rstn) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Targets are decoded from the next state so the registered outputs line up with o_state.
    always_comb begin
        sleep_req_d  = 1'b0;
        clk_en_d     = 1'b1;
        iso_d        = 1'b0;
        ret_d        = 1'b0;
        rstn_d       = 1'b1;
        pwr_on_req_d = 1'b1;
        in_sleep_d   = 1'b0;
        case (state_d)
            ST_SLP_REQ: begin
                sleep_req_d = 1'b1;
            end
            ST_OFF_SEQ: begin
                sleep_req_d  = 1'b1;
                clk_en_d     = 1'b0;
                rstn_d       = 1'b0;
                iso_d        = pg_d;
                ret_d        = pg_d;
                pwr_on_req_d = !pg_d;
            end
            ST_SLEEP: begin
                sleep_req_d  = 1'b1;
                clk_en_d     = 1'b0;
                rstn_d       = 1'b0;
                iso_d        = pg_d;
                ret_d        = pg_d;
                pwr_on_req_d = !pg_d;
                in_sleep_d   = 1'b1;
            end
            ST_PWR_UP: begin
                clk_en_d     = 1'b0;
                rstn_d       = 1'b0;
                iso_d        = pg_d;
                ret_d        = pg_d;
                pwr_on_req_d = 1'b1;
            end
            default: begin
                sleep_req_d = 1'b0;
            end
        endcase
        abort_d   = (state_q == ST_SLP_REQ) && (state_d == ST_RUN);
        timeout_d = o_ack_timeout || ((state_q == ST_PWR_UP) && cnt_max && !i_pwr_on_ack);
    end

    always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
        if (i_soc_pwr_on_rst) begin
            o_sleep_req      <= 1'b0;
            o_clk_en         <= 1'b1;
            o_iso            <= 1'b0;
            o_ret            <= 1'b0;
            o_rstn           <= 1'b1;
            o_pwr_on_req_fsm <= 1'b1;
            o_in_sleep       <= 1'b0;
            o_sleep_abort    <= 1'b0;
            o_ack_timeout    <= 1'b0;
        end else begin
            o_sleep_req      <= sleep_req_d;
            o_clk_en         <= clk_en_d;
            o_iso            <= iso_d;
            o_ret            <= ret_d;
            o_rstn           <= rstn_d;
            o_pwr_on_req_fsm <= pwr_on_req_d;
            o_in_sleep       <= in_sleep_d;
            o_sleep_abort    <= abort_d;
            o_ack_timeout    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pd1_pwr_ctrl_fsm.sv
// Directed bench for pd1_pwr_ctrl_fsm with a 5-cycle delay-line model of the sequencer.
// Expected states and outputs are queued cycle by cycle and compared one cycle later.
`timescale 1ns/1ps

module tb_pd1_pwr_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sleep_req, wakeup_req, pg_en, hw_sleep_ack, pwr_on_ack;
    logic       seq_clk_en, seq_iso, seq_rstn, seq_pwr_on_req;
    logic       o_sleep_req, o_clk_en, o_iso, o_ret, o_rstn, o_pwr_on_req_fsm;
    logic       o_in_sleep, o_sleep_abort, o_ack_timeout;
    logic [2:0] o_state;

    // Output vector order: sleep_req clk_en iso ret rstn pwr_on_req in_sleep abort timeout
    localparam logic [8:0] O_RUN       = 9'b010011000;
    localparam logic [8:0] O_RUN_ABORT = 9'b010011010;
    localparam logic [8:0] O_SLP       = 9'b110011000;
    localparam logic [8:0] O_OFF_PG    = 9'b101100000;
    localparam logic [8:0] O_SLEEP_PG  = 9'b101100100;
    localparam logic [8:0] O_PWRUP_PG  = 9'b001101000;
    localparam logic [8:0] O_OFF_NPG   = 9'b100001000;
    localparam logic [8:0] O_SLEEP_NPG = 9'b100001100;
    localparam logic [8:0] O_PWRUP_NPG = 9'b000001000;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [8:0] outs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic to_exp = 1'b0;

    logic [4:0] sq_clk, sq_iso, sq_rstn, sq_pwr;

    pd1_pwr_ctrl_fsm #(.ACK_TIMEOUT(8), .TMR_W(16)) dut (
        .i_aon_clk        (clk),
        .i_soc_pwr_on_rst (rst),
        .i_sleep_req      (sleep_req),
        .i_wakeup_req     (wakeup_req),
        .i_pg_en          (pg_en),
        .i_hw_sleep_ack   (hw_sleep_ack),
        .i_pwr_on_ack     (pwr_on_ack),
        .i_seq_clk_en     (seq_clk_en),
        .i_seq_iso        (seq_iso),
        .i_seq_rstn       (seq_rstn),
        .i_seq_pwr_on_req (seq_pwr_on_req),
        .o_sleep_req      (o_sleep_req),
        .o_clk_en         (o_clk_en),
        .o_iso            (o_iso),
        .o_ret            (o_ret),
        .o_rstn           (o_rstn),
        .o_pwr_on_req_fsm (o_pwr_on_req_fsm),
        .o_in_sleep       (o_in_sleep),
        .o_sleep_abort    (o_sleep_abort),
        .o_ack_timeout    (o_ack_timeout),
        .o_state          (o_state)
    );

    always #5 clk = ~clk;

    // Sequencer stand-in: each feedback reproduces its target five clocks later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_clk  <= '1;
            sq_iso  <= '0;
            sq_rstn <= '1;
            sq_pwr  <= '1;
        end else begin
            sq_clk  <= {sq_clk[3:0], o_clk_en};
            sq_iso  <= {sq_iso[3:0], o_iso};
            sq_rstn <= {sq_rstn[3:0], o_rstn};
            sq_pwr  <= {sq_pwr[3:0], o_pwr_on_req_fsm};
        end
    end

    assign seq_clk_en     = sq_clk[4];
    assign seq_iso        = sq_iso[4];
    assign seq_rstn       = sq_rstn[4];
    assign seq_pwr_on_req = sq_pwr[4];

    function automatic logic [8:0] obsVec();
        return {o_sleep_req, o_clk_en, o_iso, o_ret, o_rstn, o_pwr_on_req_fsm,
                o_in_sleep, o_sleep_abort, o_ack_timeout};
    endfunction

    task automatic applyStimulus(input logic sleep, input logic wake, input logic pg,
                                 input logic hwack, input logic pwrack);
        sleep_req    = sleep;
        wakeup_req   = wake;
        pg_en        = pg;
        hw_sleep_ack = hwack;
        pwr_on_ack   = pwrack;
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [11:0] got;
        logic [11:0] want;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: observed empty queue, required one entry");
        end else begin
            e    = sb.pop_front();
            got  = {o_state, obsVec()};
            want = {e.st, e.outs};
            assert (got === want) else begin
                errors++;
                $error("[TB] FAIL %s: observed state=%0d outs=%b, expected state=%0d outs=%b",
                       e.tag, got[11:9], got[8:0], want[11:9], want[8:0]);
            end
        end
    endtask

    task automatic expectNow(input string tag, input logic [2:0] st, input logic [8:0] o);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.outs = o | {8'b0, to_exp};
        sb.push_back(e);
    endtask

    task automatic steps(input string tag, input int n, input logic [2:0] st, input logic [8:0] o);
        for (int i = 0; i < n; i++) begin
            expectNow(tag, st, o);
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        expectNow("reset", 3'd0, O_RUN);
        checkOutput();
        rst = 1'b0;
        steps("run_idle", 1, 3'd0, O_RUN);

        $display("[TB] power-gated sleep entry");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        steps("t1_slp_req", 3, 3'd1, O_SLP);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        steps("t1_off_entry", 1, 3'd2, O_OFF_PG);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        steps("t1_off", 1, 3'd2, O_OFF_PG);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        steps("t1_off_wake_ignored", 2, 3'd2, O_OFF_PG);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        steps("t1_off_wait_fb", 2, 3'd2, O_OFF_PG);
        steps("t1_sleep", 2, 3'd3, O_SLEEP_PG);

        $display("[TB] power-gated wakeup");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        steps("t2_pwr_up", 1, 3'd4, O_PWRUP_PG);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        steps("t2_pwr_up_wait", 3, 3'd4, O_PWRUP_PG);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        steps("t2_on_seq", 6, 3'd5, O_RUN);
        steps("t2_run", 1, 3'd0, O_RUN);

        $display("[TB] clock-gate-only sleep and wake");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        steps("t3_slp_req", 1, 3'd1, O_SLP);
        steps("t3_off_entry", 1, 3'd2, O_OFF_NPG);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        steps("t3_off", 5, 3'd2, O_OFF_NPG);
        steps("t3_sleep", 1, 3'd3, O_SLEEP_NPG);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        steps("t3_pwr_up_one", 1, 3'd4, O_PWRUP_NPG);
        steps("t3_on_seq", 6, 3'd5, O_RUN);
        steps("t3_run", 1, 3'd0, O_RUN);

        $display("[TB] sleep handshake aborts");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        steps("t4_slp_req_wait", 9, 3'd1, O_SLP);
        steps("t4_timeout_abort", 1, 3'd0, O_RUN_ABORT);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        steps("t4_abort_clear", 1, 3'd0, O_RUN);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        steps("t4b_slp_req", 1, 3'd1, O_SLP);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        steps("t4b_wake_beats_ack", 1, 3'd0, O_RUN_ABORT);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        steps("t4b_abort_clear", 1, 3'd0, O_RUN);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        steps("t4c_slp_req", 1, 3'd1, O_SLP);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        steps("t4c_req_drop_abort", 1, 3'd0, O_RUN_ABORT);
        steps("t4c_abort_clear", 1, 3'd0, O_RUN);

        $display("[TB] power-on ack timeout");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        steps("t5_slp_req", 1, 3'd1, O_SLP);
        steps("t5_off_entry", 1, 3'd2, O_OFF_PG);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        steps("t5_off", 5, 3'd2, O_OFF_PG);
        steps("t5_sleep", 1, 3'd3, O_SLEEP_PG);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        steps("t5_pwr_up_wait", 9, 3'd4, O_PWRUP_PG);
        to_exp = 1'b1;
        steps("t5_timeout_set", 2, 3'd4, O_PWRUP_PG);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        steps("t5_on_seq", 6, 3'd5, O_RUN);
        steps("t5_run_sticky", 1, 3'd0, O_RUN);

        $display("[TB] reset during OFF_SEQ");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        steps("t6_slp_req", 1, 3'd1, O_SLP);
        steps("t6_off_entry", 1, 3'd2, O_OFF_PG);
        #2;
        rst = 1'b1;
        to_exp = 1'b0;
        #1;
        checks++;
        assert (obsVec() === O_RUN) else begin
            errors++;
            $error("[TB] FAIL t6_async_outputs: observed outs=%b, expected outs=%b", obsVec(), O_RUN);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        steps("t6_reset_state", 1, 3'd0, O_RUN);
        #2;
        rst = 1'b0;
        steps("t6_run_after_reset", 2, 3'd0, O_RUN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
